// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction fetch front end. It owns the fetch PC and sends requests to
//   a variable-latency instruction memory. At most one request is in flight
//   at a time. Returned instructions are tagged with their PC and held in a
//   FIFO_DEPTH-entry queue that feeds decode. A redirect flushes the queue
//   and drops any response still in flight.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   stall_F        in   decode not accepting; hold the queue head
//   redirect_valid in   taken branch/jump this cycle
//   redirect_pc    in   redirect target (bits [1:0] ignored)
//   imem_req       out  request valid to instruction memory
//   imem_addr      out  request address
//   imem_ready     in   memory accepts the request this cycle
//   imem_rvalid    in   response data valid
//   imem_rdata     in   response instruction
//   valid_F        out  queue head holds a valid instruction
//   instr_F        out  queue head instruction (0 when empty)
//   PCPlus4_F      out  queue head PC + 4 (0 when empty)
//   queue_count    out  occupied queue entries
module fetch_queue_unit #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          stall_F,
   input  logic                          redirect_valid,
   input  logic [ADDR_W-1:0]             redirect_pc,
   output logic                          imem_req,
   output logic [ADDR_W-1:0]             imem_addr,
   input  logic                          imem_ready,
   input  logic                          imem_rvalid,
   input  logic [DATA_W-1:0]             imem_rdata,
   output logic                          valid_F,
   output logic [DATA_W-1:0]             instr_F,
   output logic [ADDR_W-1:0]             PCPlus4_F,
   output logic [$clog2(FIFO_DEPTH):0]   queue_count
);

   localparam int               PTR_W   = $clog2(FIFO_DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DISCARD
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_fetch_pc, w_fetch_pc_nxt;
   logic [ADDR_W-1:0]   r_req_pc;
   logic                r_active;

   logic [ADDR_W-1:0]   r_pc_q   [FIFO_DEPTH];
   logic [DATA_W-1:0]   r_data_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]    r_count;

   logic                w_empty, w_issue, w_accept, w_push, w_pop;

   assign w_empty  = (r_count == '0);
   // Only IDLE issues, so nothing is outstanding there and the slot check
   // reduces to count < depth. Pops in the same cycle are not credited.
   // r_active holds off the first request until the cycle after reset
   // release.
   assign w_issue  = (r_state == S_IDLE) && r_active && (r_count < DEPTH_C)
                     && !redirect_valid;
   assign w_accept = w_issue && imem_ready;
   assign w_push   = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
   assign w_pop    = !w_empty && !stall_F && !redirect_valid;

   assign imem_req  = w_issue;
   assign imem_addr = r_fetch_pc;

   // Next state and next fetch PC
   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
               w_state_nxt    = S_WAIT;
            end
         end
         S_WAIT:    if (imem_rvalid) w_state_nxt = S_IDLE;
         S_DISCARD: if (imem_rvalid) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
      if (redirect_valid) begin
         w_fetch_pc_nxt = redirect_pc & ~ADDR_W'(3);
         // A response still owed (WAIT or DISCARD, not arriving now) has to
         // be swallowed. Nothing can be accepted in a redirect cycle because
         // the request is suppressed.
         w_state_nxt    = ((r_state != S_IDLE) && !imem_rvalid) ? S_DISCARD : S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= RESET_PC;
         r_active   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_active   <= 1'b1;
         if (w_accept) r_req_pc <= r_fetch_pc;
      end
   end

   // Queue pointers and occupancy. A redirect wins over any push or pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (redirect_valid) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage needs no reset; the head outputs are gated by occupancy.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_q[r_wr_ptr]   <= r_req_pc;
         r_data_q[r_wr_ptr] <= imem_rdata;
      end
   end

   assign valid_F     = !w_empty;
   assign instr_F     = w_empty ? '0 : r_data_q[r_rd_ptr];
   assign PCPlus4_F   = w_empty ? '0 : r_pc_q[r_rd_ptr] + ADDR_W'(4);
   assign queue_count = r_count;

   // An underflow would wrap the count to all ones, which is above the
   // depth, so the bound check covers both directions.
   a_count_bound: assert property (@(posedge clk) disable iff (!reset)
      r_count <= DEPTH_C);
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      (w_push && !w_pop) |-> (r_count < DEPTH_C));

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;
   localparam int          AW     = 32;
   localparam int          DW     = 32;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0;

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic                     stall_F = 1'b0;
   logic                     redirect_valid = 1'b0;
   logic [AW-1:0]            redirect_pc = '0;
   logic                     imem_req;
   logic [AW-1:0]            imem_addr;
   logic                     imem_ready = 1'b0;
   logic                     imem_rvalid = 1'b0;
   logic [DW-1:0]            imem_rdata = '0;
   logic                     valid_F;
   logic [DW-1:0]            instr_F;
   logic [AW-1:0]            PCPlus4_F;
   logic [$clog2(DEPTH):0]   queue_count;

   always #5 clk = ~clk;

   fetch_queue_unit #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset), .stall_F(stall_F),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .valid_F(valid_F), .instr_F(instr_F), .PCPlus4_F(PCPlus4_F),
      .queue_count(queue_count)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: the decode queue is a list of PCs; the memory holds
   // at most one pending request, marked dead once a redirect passes it.
   logic [31:0] q[$];
   logic [31:0] model_pc = RST_PC;
   bit          active = 0;
   bit          mem_pend = 0;
   bit          mem_dead = 0;
   logic [31:0] mem_addr = '0;
   int          mem_cnt = 0;
   int          lat = 1;
   bit          lat_rand = 0;
   bit          stray = 0;
   logic [31:0] acc_log[$];
   logic [31:0] pop_log[$];

   function automatic logic [31:0] code(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_at(input string tag, input logic [31:0] lg[$], input int i,
                         input logic [31:0] e);
      if (i < lg.size()) chk(tag, lg[i], e);
      else chk({tag, "_missing"}, lg.size(), i + 1);
   endtask

   // One clock cycle: drive at posedge+1, check at negedge, advance model.
   task automatic cycle(input bit stall, input bit redir, input logic [31:0] rpc, input bit rdy);
      bit deliver, exp_req, pop;
      deliver        = mem_pend && (mem_cnt == 0);
      stall_F        = stall;
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_ready     = rdy;
      imem_rvalid    = deliver || stray;
      imem_rdata     = deliver ? code(mem_addr) : $urandom;
      @(negedge clk);
      exp_req = active && !mem_pend && (q.size() < DEPTH) && !redir;
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr, model_pc);
      chk("queue_count", 32'(queue_count), q.size());
      chk("valid_F", 32'(valid_F), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("instr_F", instr_F, code(q[0]));
         chk("PCPlus4_F", PCPlus4_F, q[0] + 32'd4);
      end else begin
         chk("instr_F_empty", instr_F, 32'h0);
         chk("PCPlus4_F_empty", PCPlus4_F, 32'h0);
      end
      pop = !redir && (q.size() != 0) && !stall;
      if (pop) begin
         pop_log.push_back(PCPlus4_F);
         void'(q.pop_front());
      end
      if (deliver) begin
         if (!mem_dead && !redir) q.push_back(mem_addr);
         mem_pend = 0;
      end else if (mem_pend) begin
         mem_cnt--;
      end
      if (exp_req && rdy) begin
         acc_log.push_back(model_pc);
         mem_pend = 1;
         mem_dead = 0;
         mem_addr = model_pc;
         mem_cnt  = (lat_rand ? int'($urandom_range(1, 4)) : lat) - 1;
         model_pc = model_pc + 32'd4;
      end
      if (redir) begin
         q.delete();
         model_pc = {rpc[31:2], 2'b00};
         if (mem_pend) mem_dead = 1;
      end
      active = 1;
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear at once.
   task automatic do_reset();
      reset          = 1'b0;
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      stall_F        = 1'b0;
      imem_ready     = 1'b0;
      #1;
      chk("rst_imem_req", 32'(imem_req), 32'h0);
      chk("rst_valid_F", 32'(valid_F), 32'h0);
      chk("rst_queue_count", 32'(queue_count), 32'h0);
      chk("rst_instr_F", instr_F, 32'h0);
      chk("rst_PCPlus4_F", PCPlus4_F, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      q.delete();
      model_pc = RST_PC;
      mem_pend = 0;
      mem_dead = 0;
      active   = 0;
      acc_log.delete();
      pop_log.delete();
   endtask

   initial begin
      int n;
      // In-order streaming, 1-cycle memory
      do_reset();
      lat = 1;
      repeat (10) cycle(0, 0, 0, 1);
      chk_at("t1_addr0", acc_log, 0, 32'h0);
      chk_at("t1_addr1", acc_log, 1, 32'h4);
      chk_at("t1_addr2", acc_log, 2, 32'h8);
      chk_at("t1_pc4_0", pop_log, 0, 32'h4);
      chk_at("t1_pc4_1", pop_log, 1, 32'h8);
      chk_at("t1_pc4_2", pop_log, 2, 32'hC);

      // Decode stalled: queue fills to depth and requests stop
      do_reset();
      repeat (20) cycle(1, 0, 0, 1);
      chk("t2_n_accepted", acc_log.size(), 32'd4);
      chk("t2_count_full", 32'(queue_count), 32'd4);
      chk("t2_req_off", 32'(imem_req), 32'h0);
      repeat (10) cycle(0, 0, 0, 1);
      chk_at("t2_pop0", pop_log, 0, 32'h4);
      chk_at("t2_pop1", pop_log, 1, 32'h8);
      chk_at("t2_pop2", pop_log, 2, 32'hC);
      chk_at("t2_pop3", pop_log, 3, 32'h10);

      // Redirect while a slow response is in flight
      do_reset();
      lat = 4;
      repeat (2) cycle(0, 0, 0, 1);
      acc_log.delete();
      pop_log.delete();
      cycle(0, 1, 32'h100, 1);
      chk("t3_count_flushed", 32'(queue_count), 32'h0);
      repeat (20) cycle(0, 0, 0, 1);
      chk_at("t3_addr", acc_log, 0, 32'h100);
      chk_at("t3_pc4", pop_log, 0, 32'h104);

      // Misaligned redirect target in IDLE
      do_reset();
      lat = 1;
      cycle(0, 0, 0, 0);
      acc_log.delete();
      cycle(0, 1, 32'h203, 0);
      repeat (6) cycle(0, 0, 0, 1);
      chk_at("t4_addr0", acc_log, 0, 32'h200);
      chk_at("t4_addr1", acc_log, 1, 32'h204);

      // PC wrap-around
      acc_log.delete();
      pop_log.delete();
      cycle(0, 1, 32'hFFFFFFFC, 1);
      repeat (10) cycle(0, 0, 0, 1);
      chk_at("t5_addr0", acc_log, 0, 32'hFFFFFFFC);
      chk_at("t5_addr1", acc_log, 1, 32'h0);
      chk_at("t5_pc4_wrap", pop_log, 0, 32'h0);
      chk_at("t5_pc4_next", pop_log, 1, 32'h4);

      // All slots committed: push and pop in the same cycle
      do_reset();
      lat = 3;
      n = 0;
      while (!(q.size() == 3 && mem_pend && mem_cnt == 0) && n < 100) begin
         cycle(1, 0, 0, 1);
         n++;
      end
      chk("t6_setup_count", 32'(queue_count), 32'd3);
      cycle(0, 0, 0, 1);
      chk("t6_count_same", 32'(queue_count), 32'd3);
      repeat (12) cycle(0, 0, 0, 1);
      chk_at("t6_pop0", pop_log, 0, 32'h4);
      chk_at("t6_pop1", pop_log, 1, 32'h8);
      chk_at("t6_pop2", pop_log, 2, 32'hC);
      chk_at("t6_pop3", pop_log, 3, 32'h10);

      // Reset while waiting, then a stray response after release
      do_reset();
      lat = 5;
      n = 0;
      while (!mem_pend && n < 10) begin
         cycle(0, 0, 0, 1);
         n++;
      end
      do_reset();
      stray = 1;
      repeat (2) cycle(0, 0, 0, 1);
      stray = 0;
      chk("t7_count_after_stray", 32'(queue_count), 32'h0);
      repeat (12) cycle(0, 0, 0, 1);
      chk_at("t7_addr0", acc_log, 0, 32'h0);
      chk_at("t7_pc4_0", pop_log, 0, 32'h4);

      // Random traffic against the model
      do_reset();
      lat_rand = 1;
      repeat (600) begin
         cycle($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 4, $urandom,
               $urandom_range(0, 99) < 70);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
